// File: rtl/alarm_scanner_pkg.sv
// Shared definitions for the alarm scanner: FSM state encoding, counter width
// and a constant-evaluable log2 helper for index widths.
package alarm_scanner_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SAMPLE = 2'b01,
      EVAL   = 2'b10,
      ADV    = 2'b11
   } state_t;

   // Wide enough for the largest persistence threshold (15).
   localparam int CNT_W = 4;

   function automatic int clog2w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/alarm_persist_cnt.sv
// Per-channel persistence filter: a saturating hit counter and an alarm latch.
// A latch-set wins over a coincident acknowledge so no alarm is lost.
module alarm_persist_cnt
   import alarm_scanner_pkg::*;
#(
   parameter int PERSIST = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic eval,
   input  logic hit,
   input  logic ack,
   output logic latch,
   output logic new_set
);

   localparam logic [CNT_W-1:0] PMAX = CNT_W'(PERSIST);

   logic [CNT_W-1:0] count;
   logic             reach;

   assign reach   = eval & hit & (count == (PMAX - 4'd1));
   assign new_set = reach & ~latch;

   // Counter and latch update; reaching saturation takes priority over ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 4'd0;
         latch <= 1'b0;
      end else if (reach) begin
         count <= PMAX;
         latch <= 1'b1;
      end else if (ack) begin
         count <= 4'd0;
         latch <= 1'b0;
      end else if (eval) begin
         if (hit) begin
            count <= (count == PMAX) ? count : count + 4'd1;
         end else begin
            count <= 4'd0;
         end
      end else begin
         count <= count;
         latch <= latch;
      end
   end

endmodule

// File: rtl/alarm_scanner.sv
// Round-robin sensor scanner: selects each channel for DWELL cycles, samples it,
// and feeds a per-channel persistence filter that raises latched alarms.
module alarm_scanner
   import alarm_scanner_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int PERSIST = 3,
   parameter int DWELL   = 2,
   localparam int IDX_W  = clog2w(N_CH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_CH-1:0]  sense,
   input  logic [N_CH-1:0]  mask,
   input  logic [N_CH-1:0]  ack,
   output logic [N_CH-1:0]  scan_sel,
   output logic [N_CH-1:0]  alarm_latch,
   output logic             alarm_pulse,
   output logic             any_alarm,
   output logic [IDX_W-1:0] alarm_ch,
   output logic             scan_done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
   localparam logic [7:0]       DW_LAST  = 8'(DWELL - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [7:0]       dwell_cnt;
   logic             sample_bit;
   logic [N_CH-1:0]  new_set;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic eval_s;
      assign eval_s = (state == EVAL) && (idx == IDX_W'(i));
      alarm_persist_cnt #(.PERSIST(PERSIST)) u_cnt (
         .clk     (clk),
         .reset   (reset),
         .eval    (eval_s),
         .hit     (sample_bit & ~mask[i]),
         .ack     (ack[i]),
         .latch   (alarm_latch[i]),
         .new_set (new_set[i])
      );
   end

   // Scan sequencer; in-flight samples are dropped by reset since state returns to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         dwell_cnt   <= 8'd0;
         sample_bit  <= 1'b0;
         alarm_pulse <= 1'b0;
         scan_done   <= 1'b0;
      end else begin
         alarm_pulse <= 1'b0;
         scan_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state     <= SAMPLE;
                  idx       <= '0;
                  dwell_cnt <= 8'd0;
               end
            end
            SAMPLE: begin
               if (dwell_cnt == DW_LAST) begin
                  sample_bit <= sense[idx];
                  state      <= EVAL;
               end else begin
                  dwell_cnt <= dwell_cnt + 8'd1;
               end
            end
            EVAL: begin
               alarm_pulse <= |new_set;
               scan_done   <= (idx == LAST_IDX);
               state       <= ADV;
            end
            ADV: begin
               dwell_cnt <= 8'd0;
               if (enable) begin
                  state <= SAMPLE;
                  idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
               end else begin
                  state <= IDLE;
                  idx   <= '0;
               end
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

   // Channel select decode and alarm summary (lowest latched index wins).
   always_comb begin
      scan_sel = '0;
      if (state == SAMPLE) begin
         scan_sel[idx] = 1'b1;
      end else begin
         scan_sel = '0;
      end
      any_alarm = |alarm_latch;
      alarm_ch  = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         alarm_ch = alarm_latch[i] ? IDX_W'(i) : alarm_ch;
      end
   end

endmodule
